tile_scan_fetch: RTL and testbench
==================================

Name: tile_scan_fetch

Overview:
- Pixel-scan initiator for the tile display ROMs.
- Consumes the VGA active-area strobe and tracks the current screen pixel as (tile column, tile row, tile-local x, tile-local y).
- Reads the map RAM to get the cell type, then drives the tile ROM lookup inputs (x, y, is_wall, sel).
- Registers the returned RGB into a valid-qualified pixel stream for the VGA output stage. Sits between the VGA timing generator and the DisplayROM blocks.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- TILE, 10, tile edge in pixels (tile-local coords 0..TILE-1)
- MAP_COLS, 64, tiles per row (H_ACTIVE/TILE)
- ANIM_FRAMES, 30, frames between toggles of the animation select

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse before the first active line of a frame
- i_de  in  1  display enable; high for each active pixel
- o_map_addr  out  12  map RAM read address = tile_row*MAP_COLS + tile_col
- o_map_re  out  1  map RAM read enable (= i_de)
- i_map_data  in  2  cell type, valid 1 cycle after o_map_re
- o_rom_x  out  4  tile-local x to tile ROM
- o_rom_y  out  4  tile-local y to tile ROM
- o_rom_is_wall  out  1  cell is a wall and the pixel is valid
- o_rom_sel  out  1  animation/colour select to tile ROM
- i_rom_rgb  in  24  combinational ROM pixel colour
- o_rgb  out  24  registered pixel colour
- o_rgb_valid  out  1  o_rgb qualifier
- o_err  out  1  sticky scan-overrun flag

Behaviour:
- Reset (i_rst_n low, async): all counters, pipeline registers, o_rom_sel, o_err, o_rgb and o_rgb_valid go to 0. o_map_addr and o_map_re are 0.
- Counters:
  - px: 0..H_ACTIVE-1, with lx 0..TILE-1 and tile_col.
  - line: ln 0..V_ACTIVE-1, with ly 0..TILE-1 and tile_row.
  - No dividers: lx wraps at TILE-1 and increments tile_col; same for ly and tile_row.
- Stage 0 (cycle N, i_de=1):
  - o_map_addr is combinational from the current tile_row/tile_col; o_map_re = i_de.
  - At the clock edge the pixel's lx, ly and de are captured into stage 1, and px/lx/tile_col advance.
- Line end: on a falling edge of i_de (de_q=1, i_de=0), px, lx and tile_col clear to 0; ly/tile_row and ln advance. A short line (early falling edge) is still a line end.
- Overrun:
  - If i_de is high with px = H_ACTIVE-1 already consumed, column counters hold at their last values and o_err sets.
  - If a line end occurs with ln = V_ACTIVE-1 already consumed, line counters hold and o_err sets.
  - o_err clears only on reset.
- Frame start: i_frame_start clears the line counters (ln, ly, tile_row) and the column counters. If it coincides with i_de=1, the reset wins and that pixel is processed as (0,0).
- Stage 1 (cycle N+1):
  - o_rom_x = lx1, o_rom_y = ly1.
  - o_rom_is_wall = de1 & (i_map_data == CELL_WALL).
  - o_rom_sel is driven from a register.
- Stage 2 (cycle N+2): o_rgb <= de1 ? i_rom_rgb : 0; o_rgb_valid <= de1. Total latency from i_de to o_rgb_valid is 2 cycles.
- Animation:
  - The frame counter increments on each i_frame_start.
  - At ANIM_FRAMES-1 it wraps to 0 and o_rom_sel toggles.
  - o_rom_sel changes only at a frame start, so it is constant within a frame.
- Pipeline flow: back-to-back pixels are fully pipelined, with no stalls or backpressure.

Decomposition:
- Shared display package holds:
  - CELL_EMPTY=0, CELL_WALL=1, CELL_BARREL=2, CELL_RSVD=3
  - the map address width
  - the TILE, H_ACTIVE and V_ACTIVE defaults
- Natural sub-module: tile_axis_counter, a pixel/local/tile triple counter with wrap, clear, hold and overrun flag. It is instantiated twice, once for columns (step=i_de) and once for lines (step=line end).

Test Plan:
- Reset mid-line with counters at px=123 -> all outputs 0 immediately; first i_de after release gives o_map_addr=0, o_rom_x=0.
- One full line of 640 i_de cycles, map all CELL_WALL:
  - o_rom_x follows 0..9 repeatedly, and o_map_addr steps 0..63 every 10 pixels.
  - o_rgb_valid rises exactly 2 cycles after i_de and stays high for 640 cycles.
- Lines 0..10 -> o_rom_y = 9 on line 9 and 0 on line 10, and on line 10 o_map_addr starts at 64. At line 479 the address reaches 47*64+63 = 3071.
- Map cell CELL_BARREL at address 5, ROM returns 24'hABCDEF -> pixels 50..59 have o_rom_is_wall=0. o_rgb equals whatever i_rom_rgb returns, with no masking.
- 30 i_frame_start pulses -> o_rom_sel toggles 0→1 on pulse 30 and 1→0 on pulse 60; no change mid-frame.
- 641 i_de cycles in one line -> o_err=1, and pixel 641 is given o_map_addr=63, o_rom_x=9. A short 100-pixel line followed by a new line restarts at px=0.

Source files
------------

// File: rtl/tile_scan_fetch_pkg.sv
// Shared display definitions: map cell types, screen geometry defaults and bus widths
// used by the tile scan front end and its testbench.
package tile_scan_fetch_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY  = 2'd0,
        CELL_WALL   = 2'd1,
        CELL_BARREL = 2'd2,
        CELL_RSVD   = 2'd3
    } cell_t;

    localparam int MAP_ADDR_W      = 12;
    localparam int ROM_COORD_W     = 4;
    localparam int RGB_W           = 24;

    localparam int TILE_DEF        = 10;
    localparam int H_ACTIVE_DEF    = 640;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int MAP_COLS_DEF    = H_ACTIVE_DEF / TILE_DEF;
    localparam int ANIM_FRAMES_DEF = 30;

endpackage

// File: rtl/tile_scan_fetch_if.sv
// Pixel-scan bus between the VGA timing source, map RAM, tile ROM and the VGA output stage.
// The master side is the scan front end; the slave side is everything around it.
interface tile_scan_fetch_if;
    import tile_scan_fetch_pkg::*;

    logic                   i_frame_start;
    logic                   i_de;
    logic [MAP_ADDR_W-1:0]  o_map_addr;
    logic                   o_map_re;
    logic [1:0]             i_map_data;
    logic [ROM_COORD_W-1:0] o_rom_x;
    logic [ROM_COORD_W-1:0] o_rom_y;
    logic                   o_rom_is_wall;
    logic                   o_rom_sel;
    logic [RGB_W-1:0]       i_rom_rgb;
    logic [RGB_W-1:0]       o_rgb;
    logic                   o_rgb_valid;
    logic                   o_err;

    modport master (
        input  i_frame_start, i_de, i_map_data, i_rom_rgb,
        output o_map_addr, o_map_re, o_rom_x, o_rom_y, o_rom_is_wall,
               o_rom_sel, o_rgb, o_rgb_valid, o_err
    );

    modport slave (
        output i_frame_start, i_de, i_map_data, i_rom_rgb,
        input  o_map_addr, o_map_re, o_rom_x, o_rom_y, o_rom_is_wall,
               o_rom_sel, o_rgb, o_rgb_valid, o_err
    );

endinterface

// File: rtl/tile_scan_fetch_axis.sv
// Pixel / tile-local / tile-index triple counter for one screen axis; the local
// coordinate wraps at TILE-1 and carries into the tile index, so no divider is needed.
module tile_axis_counter #(
    parameter int PIX_MAX = 640,
    parameter int TILE    = 10,
    parameter int LOC_W   = 4,
    parameter int TILE_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    output logic [LOC_W-1:0]  loc,
    output logic [TILE_W-1:0] tile,
    output logic              overrun
);

    localparam int               PIX_W    = $clog2(PIX_MAX);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_MAX - 1);
    localparam logic [LOC_W-1:0] LOC_LAST = LOC_W'(TILE - 1);

    logic [PIX_W-1:0]  pix_q, pix_c, pix_n;
    logic [LOC_W-1:0]  loc_q, loc_c, loc_n;
    logic [TILE_W-1:0] tile_q, tile_c, tile_n;
    logic              full_q, full_c, full_n;

    // A clear in the same cycle as a step makes that step count as position zero.
    always_comb begin
        pix_c  = clear ? '0   : pix_q;
        loc_c  = clear ? '0   : loc_q;
        tile_c = clear ? '0   : tile_q;
        full_c = clear ? 1'b0 : full_q;
    end

    assign loc     = loc_c;
    assign tile    = tile_c;
    assign overrun = step & full_c;

    // Once the last position is consumed the counter freezes there and further steps overrun.
    always_comb begin
        pix_n  = pix_c;
        loc_n  = loc_c;
        tile_n = tile_c;
        full_n = full_c;
        if (step && !full_c) begin
            if (pix_c == PIX_LAST) begin
                full_n = 1'b1;
            end else begin
                pix_n = pix_c + 1'b1;
                if (loc_c == LOC_LAST) begin
                    loc_n  = '0;
                    tile_n = tile_c + 1'b1;
                end else begin
                    loc_n = loc_c + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q  <= '0;
            loc_q  <= '0;
            tile_q <= '0;
            full_q <= 1'b0;
        end else begin
            pix_q  <= pix_n;
            loc_q  <= loc_n;
            tile_q <= tile_n;
            full_q <= full_n;
        end
    end

endmodule

// File: rtl/tile_scan_fetch.sv
// Tile display scan front end: tracks the active pixel, fetches its map cell, drives the
// tile ROM lookup and registers the returned colour as a valid-qualified pixel stream.
module tile_scan_fetch
    import tile_scan_fetch_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int TILE        = TILE_DEF,
    parameter int MAP_COLS    = MAP_COLS_DEF,
    parameter int ANIM_FRAMES = ANIM_FRAMES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    tile_scan_fetch_if.master bus
);

    localparam int LOC_W = $clog2(TILE);
    localparam int COL_W = $clog2(MAP_COLS);
    localparam int ROW_W = $clog2(V_ACTIVE / TILE);
    localparam int FC_W  = $clog2(ANIM_FRAMES);

    logic [LOC_W-1:0] lx, ly, lx1, ly1;
    logic [COL_W-1:0] tile_col;
    logic [ROW_W-1:0] tile_row;
    logic             de1;
    logic             line_end;
    logic             col_clear;
    logic             row_step;
    logic             col_ovr, row_ovr;
    logic [FC_W-1:0]  frame_cnt;
    logic             sel_q;
    logic             err_q;
    logic [RGB_W-1:0] rgb_q;
    logic             rgb_valid_q;

    // de1 doubles as the previous-cycle display enable for falling-edge detection.
    assign line_end  = de1 & ~bus.i_de;
    assign col_clear = bus.i_frame_start | line_end;
    assign row_step  = line_end & ~bus.i_frame_start;

    tile_axis_counter #(
        .PIX_MAX (H_ACTIVE),
        .TILE    (TILE),
        .LOC_W   (LOC_W),
        .TILE_W  (COL_W)
    ) u_col (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (col_clear),
        .step    (bus.i_de),
        .loc     (lx),
        .tile    (tile_col),
        .overrun (col_ovr)
    );

    tile_axis_counter #(
        .PIX_MAX (V_ACTIVE),
        .TILE    (TILE),
        .LOC_W   (LOC_W),
        .TILE_W  (ROW_W)
    ) u_row (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (bus.i_frame_start),
        .step    (row_step),
        .loc     (ly),
        .tile    (tile_row),
        .overrun (row_ovr)
    );

    assign bus.o_map_addr = MAP_ADDR_W'(tile_row) * MAP_ADDR_W'(MAP_COLS) + MAP_ADDR_W'(tile_col);
    assign bus.o_map_re   = bus.i_de & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            de1 <= 1'b0;
            lx1 <= '0;
            ly1 <= '0;
        end else begin
            de1 <= bus.i_de;
            lx1 <= lx;
            ly1 <= ly;
        end
    end

    assign bus.o_rom_x       = ROM_COORD_W'(lx1);
    assign bus.o_rom_y       = ROM_COORD_W'(ly1);
    assign bus.o_rom_is_wall = de1 & (bus.i_map_data == CELL_WALL);
    assign bus.o_rom_sel     = sel_q;

    // Animation select only flips on a frame start so a frame never mixes two variants.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt <= '0;
            sel_q     <= 1'b0;
        end else if (bus.i_frame_start) begin
            if (frame_cnt == FC_W'(ANIM_FRAMES - 1)) begin
                frame_cnt <= '0;
                sel_q     <= ~sel_q;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q       <= 1'b0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            err_q       <= err_q | col_ovr | row_ovr;
            rgb_q       <= de1 ? bus.i_rom_rgb : '0;
            rgb_valid_q <= de1;
        end
    end

    assign bus.o_err       = err_q;
    assign bus.o_rgb       = rgb_q;
    assign bus.o_rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_tile_scan_fetch.sv
// Scoreboard bench for tile_scan_fetch: a divider-based reference of the scan position
// predicts every fetch, ROM lookup and output pixel, queued until the DUT emits it.
module tb_tile_scan_fetch;
    import tile_scan_fetch_pkg::*;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       wall;
        logic       sel;
    } rom_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rom_force;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  map_mem [4096];
    rom_exp_t    q_rom [$];
    logic [23:0] q_rgb [$];

    int   m_px, m_ln, m_fc;
    bit   m_colfull, m_rowfull, m_prev_de, m_err, m_sel;
    bit   d1, d2;
    logic [11:0] last_addr;
    logic [3:0]  last_romx;

    always #5 clk = ~clk;

    tile_scan_fetch_if bus();

    tile_scan_fetch dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    function automatic logic [23:0] romModel(input logic [3:0] x, input logic [3:0] y,
                                             input logic wall, input logic sel, input logic frc);
        romModel = frc ? 24'hABCDEF : {4'hC, x, y, 3'b000, wall, 7'b0000000, sel};
    endfunction

    // Map RAM answers one cycle after the address; ROM is purely combinational.
    always @(posedge clk) bus.i_map_data <= map_mem[bus.o_map_addr];
    assign bus.i_rom_rgb = romModel(bus.o_rom_x, bus.o_rom_y, bus.o_rom_is_wall, bus.o_rom_sel, rom_force);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic resetModel();
        m_px = 0; m_ln = 0; m_fc = 0;
        m_colfull = 0; m_rowfull = 0; m_prev_de = 0; m_err = 0; m_sel = 0;
        d1 = 0; d2 = 0;
        q_rom.delete();
        q_rgb.delete();
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_map_addr", 32'(bus.o_map_addr), 32'd0);
        checkOutput("rst_map_re", 32'(bus.o_map_re), 32'd0);
        checkOutput("rst_rom_x", 32'(bus.o_rom_x), 32'd0);
        checkOutput("rst_rom_y", 32'(bus.o_rom_y), 32'd0);
        checkOutput("rst_is_wall", 32'(bus.o_rom_is_wall), 32'd0);
        checkOutput("rst_rom_sel", 32'(bus.o_rom_sel), 32'd0);
        checkOutput("rst_rgb", 32'(bus.o_rgb), 32'd0);
        checkOutput("rst_rgb_valid", 32'(bus.o_rgb_valid), 32'd0);
        checkOutput("rst_err", 32'(bus.o_err), 32'd0);
    endtask

    // Asynchronous reset in the middle of a cycle, then release one edge later.
    task automatic doReset();
        #3;
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resetModel();
    endtask

    // One pixel clock: drive, predict, check at the falling edge, advance past the rising edge.
    task automatic applyStimulus(input bit de, input bit fs);
        rom_exp_t e;
        int       exp_addr;
        bit       nxt_err, nxt_sel;
        logic [23:0] exp_rgb;

        bus.i_de          = de;
        bus.i_frame_start = fs;
        nxt_err  = m_err;
        nxt_sel  = m_sel;
        exp_addr = 0;

        if (fs) begin
            m_px = 0; m_ln = 0; m_colfull = 0; m_rowfull = 0;
            if (m_fc == ANIM_FRAMES_DEF - 1) begin
                m_fc    = 0;
                nxt_sel = ~m_sel;
            end else begin
                m_fc++;
            end
        end
        if (m_prev_de && !de) begin
            m_px = 0; m_colfull = 0;
            if (!fs) begin
                if (m_rowfull) nxt_err = 1;
                else if (m_ln == V_ACTIVE_DEF - 1) m_rowfull = 1;
                else m_ln++;
            end
        end
        if (de) begin
            exp_addr = (m_ln / TILE_DEF) * MAP_COLS_DEF + (m_px / TILE_DEF);
            e.x    = 4'(m_px % TILE_DEF);
            e.y    = 4'(m_ln % TILE_DEF);
            e.wall = (map_mem[exp_addr] == CELL_WALL);
            e.sel  = nxt_sel;
            q_rom.push_back(e);
            q_rgb.push_back(romModel(e.x, e.y, e.wall, e.sel, rom_force));
            if (m_colfull) nxt_err = 1;
            else if (m_px == H_ACTIVE_DEF - 1) m_colfull = 1;
            else m_px++;
        end
        m_prev_de = de;

        @(negedge clk);
        checkOutput("map_re", 32'(bus.o_map_re), 32'(de));
        if (de) begin
            checkOutput("map_addr", 32'(bus.o_map_addr), 32'(exp_addr));
            last_addr = bus.o_map_addr;
        end
        if (d1) begin
            e = '0;
            if (q_rom.size() != 0) e = q_rom.pop_front();
            checkOutput("rom_x", 32'(bus.o_rom_x), 32'(e.x));
            checkOutput("rom_y", 32'(bus.o_rom_y), 32'(e.y));
            checkOutput("rom_is_wall", 32'(bus.o_rom_is_wall), 32'(e.wall));
            last_romx = bus.o_rom_x;
        end else begin
            checkOutput("is_wall_idle", 32'(bus.o_rom_is_wall), 32'd0);
        end
        checkOutput("rgb_valid", 32'(bus.o_rgb_valid), 32'(d2));
        if (d2) begin
            exp_rgb = '0;
            if (q_rgb.size() != 0) exp_rgb = q_rgb.pop_front();
            checkOutput("rgb", 32'(bus.o_rgb), 32'(exp_rgb));
        end else begin
            checkOutput("rgb_idle", 32'(bus.o_rgb), 32'd0);
        end
        checkOutput("err", 32'(bus.o_err), 32'(m_err));
        checkOutput("rom_sel", 32'(bus.o_rom_sel), 32'(m_sel));
        d2 = d1;
        d1 = de;

        @(posedge clk);
        #1;
        m_err = nxt_err;
        m_sel = nxt_sel;
    endtask

    initial begin
        bus.i_de          = 1'b0;
        bus.i_frame_start = 1'b0;
        rom_force         = 1'b0;
        last_addr         = '0;
        last_romx         = '0;
        for (int i = 0; i < 4096; i++) map_mem[i] = CELL_WALL;
        map_mem[5] = CELL_BARREL;
        resetModel();

        #2;
        checkResetOutputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        resetModel();

        $display("[TB] reset mid-line at px=123");
        applyStimulus(0, 1);
        repeat (123) applyStimulus(1, 0);
        doReset();
        repeat (15) applyStimulus(1, 0);
        repeat (4) applyStimulus(0, 0);

        $display("[TB] full frame: lines 0..10, barrel at cell 5, short lines, line 479");
        applyStimulus(0, 1);
        rom_force = 1'b1;
        for (int ln = 0; ln <= 10; ln++) begin
            repeat (640) applyStimulus(1, 0);
            repeat (4) applyStimulus(0, 0);
            rom_force = 1'b0;
        end
        for (int ln = 11; ln <= 478; ln++) begin
            applyStimulus(1, 0);
            applyStimulus(0, 0);
        end
        repeat (640) applyStimulus(1, 0);
        checkOutput("addr_line479_end", 32'(last_addr), 32'd3071);
        repeat (4) applyStimulus(0, 0);
        applyStimulus(1, 0);
        repeat (3) applyStimulus(0, 0);
        checkOutput("line_overrun_err", 32'(bus.o_err), 32'd1);

        $display("[TB] column overrun and short line");
        doReset();
        applyStimulus(0, 1);
        repeat (641) applyStimulus(1, 0);
        checkOutput("ovr_pixel_addr", 32'(last_addr), 32'd63);
        applyStimulus(0, 0);
        checkOutput("ovr_pixel_rom_x", 32'(last_romx), 32'd9);
        checkOutput("col_overrun_err", 32'(bus.o_err), 32'd1);
        repeat (3) applyStimulus(0, 0);
        repeat (100) applyStimulus(1, 0);
        repeat (4) applyStimulus(0, 0);
        repeat (20) applyStimulus(1, 0);
        repeat (4) applyStimulus(0, 0);

        $display("[TB] animation select over 60 frame starts");
        doReset();
        for (int f = 1; f <= 60; f++) begin
            applyStimulus(f % 2, 1);
            repeat (3) applyStimulus(1, 0);
            applyStimulus(0, 0);
            if (f == 29) checkOutput("sel_after_29", 32'(bus.o_rom_sel), 32'd0);
            if (f == 30) checkOutput("sel_after_30", 32'(bus.o_rom_sel), 32'd1);
            if (f == 59) checkOutput("sel_after_59", 32'(bus.o_rom_sel), 32'd1);
            if (f == 60) checkOutput("sel_after_60", 32'(bus.o_rom_sel), 32'd0);
        end
        repeat (3) applyStimulus(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
